// File: rtl/pe_array_pkg.sv
// Shared definitions for the PE-array data-delivery blocks: default widths,
// the broadcast tag and the multicast controller state encoding.
package pe_array_pkg;

  localparam int DEFAULT_BITWIDTH = 16;
  localparam int DEFAULT_ID_WIDTH = 4;

  // A beat carrying the all-ones tag is accepted by every controller.
  localparam logic [DEFAULT_ID_WIDTH-1:0] BROADCAST_TAG = '1;

  typedef enum logic {
    UNCFG = 1'b0,
    RUN   = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a separately held count and a head that is read
// combinationally. Storage is cleared by reset so the head reads 0 until written.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [WIDTH-1:0] mem_view [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
          entry_reg <= '0;
        end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_reg <= wr_data;
        end
      end
      assign mem_view[gi] = entry_reg;
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem_view[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/multicast_controller.sv
// Tag-matching receive buffer feeding one PE data input: filters the shared
// broadcast bus by ID, queues accepted beats and pulses pe_enable per word.
module multicast_controller
  import pe_array_pkg::*;
#(
  parameter int BITWIDTH = DEFAULT_BITWIDTH,
  parameter int ID_WIDTH = DEFAULT_ID_WIDTH,
  parameter int DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       cfg_en,
  input  logic [ID_WIDTH-1:0]        cfg_id,
  input  logic                       bus_valid,
  input  logic [ID_WIDTH-1:0]        bus_tag,
  input  logic signed [BITWIDTH-1:0] bus_data,
  output logic                       bus_ready,
  input  logic                       pe_ready,
  output logic                       pe_enable,
  output logic signed [BITWIDTH-1:0] pe_data,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [15:0]                drop_count
);

  ctrl_state_e         state_reg;
  ctrl_state_e         state_next;
  logic [ID_WIDTH-1:0] id_reg;
  logic [15:0]         drop_count_reg;

  logic                run;
  logic                match;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                drop;
  logic [BITWIDTH-1:0] head_data;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= UNCFG;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (cfg_en) state_next = RUN;
  end

  assign run = (state_reg == RUN);

  // All-ones tag is the broadcast address at any ID width.
  assign match = (bus_tag == id_reg) | (&bus_tag);

  // Full blocks acceptance even on a popping cycle, keeping bus_ready off pe_ready.
  assign bus_ready = run & (~match | ~fifo_full);
  assign push      = bus_valid & bus_ready & match & run & ~cfg_en;
  assign drop      = bus_valid & ~match & run;
  assign pe_enable = pe_ready & ~fifo_empty & run;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      id_reg         <= '0;
      drop_count_reg <= '0;
    end else begin
      if (cfg_en) id_reg <= cfg_id;
      if (drop && (drop_count_reg != 16'hFFFF)) drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

  sync_fifo #(
    .WIDTH (BITWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .flush   (cfg_en),
    .push    (push),
    .pop     (pe_enable),
    .wr_data (bus_data),
    .rd_data (head_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (occupancy)
  );

  assign pe_data    = head_data;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_multicast_controller.sv
// Directed-vector bench for multicast_controller: each row drives one cycle and
// carries the hand-computed mid-cycle and post-edge expectations.
module tb_multicast_controller;
  import pe_array_pkg::*;

  localparam int BW    = 16;
  localparam int IW    = 4;
  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rstb = 1'b0;
  logic                 cfg_en = 1'b0;
  logic [IW-1:0]        cfg_id = '0;
  logic                 bus_valid = 1'b0;
  logic [IW-1:0]        bus_tag = '0;
  logic signed [BW-1:0] bus_data = '0;
  logic                 bus_ready;
  logic                 pe_ready = 1'b0;
  logic                 pe_enable;
  logic signed [BW-1:0] pe_data;
  logic [2:0]           occupancy;
  logic [15:0]          drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicast_controller #(
    .BITWIDTH (BW),
    .ID_WIDTH (IW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .cfg_en     (cfg_en),
    .cfg_id     (cfg_id),
    .bus_valid  (bus_valid),
    .bus_tag    (bus_tag),
    .bus_data   (bus_data),
    .bus_ready  (bus_ready),
    .pe_ready   (pe_ready),
    .pe_enable  (pe_enable),
    .pe_data    (pe_data),
    .occupancy  (occupancy),
    .drop_count (drop_count)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic                 cfg_en;
    logic [IW-1:0]        cfg_id;
    logic                 valid;
    logic [IW-1:0]        tag;
    logic signed [BW-1:0] data;
    logic                 pe_ready;
    logic                 exp_bus_ready;
    logic                 exp_pe_enable;
    logic signed [BW-1:0] exp_pe_data;
    logic [2:0]           exp_occ;
    logic [15:0]          exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic c, input int id, input logic v, input int tag, input int data,
                         input logic pr, input logic br, input logic pe, input int pd,
                         input int occ, input int drop);
    vec_t x;
    x.cfg_en        = c;
    x.cfg_id        = id[IW-1:0];
    x.valid         = v;
    x.tag           = tag[IW-1:0];
    x.data          = data[BW-1:0];
    x.pe_ready      = pr;
    x.exp_bus_ready = br;
    x.exp_pe_enable = pe;
    x.exp_pe_data   = pd[BW-1:0];
    x.exp_occ       = occ[2:0];
    x.exp_drop      = drop[15:0];
    vecs.push_back(x);
  endtask

  initial begin
    //       cfg id  v  tag data  prdy | br pe pdata occ drop
    // unconfigured: beat refused, nothing counted
    add_vec(0, 0, 1,  3, 123, 1,  0, 0,  0,  0, 0);
    add_vec(1, 5, 0,  0,   0, 1,  0, 0,  0,  0, 0);
    // tags 5,5,2,15 with pe_ready high
    add_vec(0, 0, 1,  5,  10, 1,  1, 0,  0,  1, 0);
    add_vec(0, 0, 1,  5,  -3, 1,  1, 1, 10,  1, 0);
    add_vec(0, 0, 1,  2,   7, 1,  1, 1, -3,  0, 1);
    add_vec(0, 0, 1, 15,  99, 1,  1, 0,  0,  1, 1);
    add_vec(0, 0, 0,  0,   0, 1,  1, 1, 99,  0, 1);
    // fill with pe_ready low, fifth beat held
    add_vec(0, 0, 1,  5,   1, 0,  1, 0,  0,  1, 1);
    add_vec(0, 0, 1,  5,   2, 0,  1, 0,  0,  2, 1);
    add_vec(0, 0, 1,  5,   3, 0,  1, 0,  0,  3, 1);
    add_vec(0, 0, 1,  5,   4, 0,  1, 0,  0,  4, 1);
    add_vec(0, 0, 1,  5,   5, 0,  0, 0,  0,  4, 1);
    // full with pop: refused this cycle, accepted next
    add_vec(0, 0, 1,  5,   5, 1,  0, 1,  1,  3, 1);
    add_vec(0, 0, 1,  5,   5, 1,  1, 1,  2,  3, 1);
    add_vec(0, 0, 0,  0,   0, 1,  1, 1,  3,  2, 1);
    add_vec(0, 0, 0,  0,   0, 1,  1, 1,  4,  1, 1);
    add_vec(0, 0, 0,  0,   0, 1,  1, 1,  5,  0, 1);
    // occupancy 3 then reconfigure to id 9 with coincident matching beat
    add_vec(0, 0, 1,  5,  11, 0,  1, 0,  0,  1, 1);
    add_vec(0, 0, 1, 15,  12, 0,  1, 0,  0,  2, 1);
    add_vec(0, 0, 1,  5,  13, 0,  1, 0,  0,  3, 1);
    add_vec(1, 9, 1,  5,  14, 0,  1, 0,  0,  0, 1);
    add_vec(0, 0, 1,  5,  15, 0,  1, 0,  0,  0, 2);
    add_vec(0, 0, 1,  9,  16, 0,  1, 0,  0,  1, 2);
    add_vec(0, 0, 0,  0,   0, 1,  1, 1, 16,  0, 2);
    // build occupancy 2 and drop_count 7 for the reset check
    add_vec(0, 0, 1,  1,   0, 0,  1, 0,  0,  0, 3);
    add_vec(0, 0, 1,  2,   0, 0,  1, 0,  0,  0, 4);
    add_vec(0, 0, 1,  3,   0, 0,  1, 0,  0,  0, 5);
    add_vec(0, 0, 1,  4,   0, 0,  1, 0,  0,  0, 6);
    add_vec(0, 0, 1,  5,   0, 0,  1, 0,  0,  0, 7);
    add_vec(0, 0, 1,  9,  21, 0,  1, 0,  0,  1, 7);
    add_vec(0, 0, 1,  9,  22, 0,  1, 0,  0,  2, 7);

    #2;
    check_value("rst_bus_ready", 32'(bus_ready), 32'd0);
    check_value("rst_pe_enable", 32'(pe_enable), 32'd0);
    check_value("rst_pe_data", 32'(pe_data), 32'd0);
    check_value("rst_occupancy", 32'(occupancy), 32'd0);
    check_value("rst_drop_count", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1;
    rstb = 1'b1;

    foreach (vecs[i]) begin
      cfg_en    = vecs[i].cfg_en;
      cfg_id    = vecs[i].cfg_id;
      bus_valid = vecs[i].valid;
      bus_tag   = vecs[i].tag;
      bus_data  = vecs[i].data;
      pe_ready  = vecs[i].pe_ready;
      #4;
      check_value($sformatf("v%0d_bus_ready", i), 32'(bus_ready), 32'(vecs[i].exp_bus_ready));
      check_value($sformatf("v%0d_pe_enable", i), 32'(pe_enable), 32'(vecs[i].exp_pe_enable));
      if (vecs[i].exp_pe_enable)
        check_value($sformatf("v%0d_pe_data", i), 32'(pe_data), 32'(vecs[i].exp_pe_data));
      @(posedge clk);
      #1;
      check_value($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
      check_value($sformatf("v%0d_drop_count", i), 32'(drop_count), 32'(vecs[i].exp_drop));
      $display("vec %0d: cfg=%0b v=%0b tag=%0d data=%0d prdy=%0b -> br=%0b en=%0b pdata=%0d occ=%0d drop=%0d",
               i, vecs[i].cfg_en, vecs[i].valid, vecs[i].tag, vecs[i].data, vecs[i].pe_ready,
               bus_ready, pe_enable, pe_data, occupancy, drop_count);
    end

    // Asynchronous reset mid-cycle with occupancy=2, drop_count=7
    cfg_en    = 1'b0;
    bus_valid = 1'b1;
    bus_tag   = 4'd9;
    pe_ready  = 1'b1;
    #3;
    rstb = 1'b0;
    #1;
    check_value("async_bus_ready", 32'(bus_ready), 32'd0);
    check_value("async_pe_enable", 32'(pe_enable), 32'd0);
    check_value("async_pe_data", 32'(pe_data), 32'd0);
    check_value("async_occupancy", 32'(occupancy), 32'd0);
    check_value("async_drop_count", 32'(drop_count), 32'd0);
    $display("async reset: br=%0b en=%0b pdata=%0d occ=%0d drop=%0d",
             bus_ready, pe_enable, pe_data, occupancy, drop_count);
    @(posedge clk);
    #1;
    rstb = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
